// File: rtl/sm_twi_engine.sv
// sm_twi_engine: single-clock I2C master engine. Runs one register write
// (START, addr+W, reg, data, STOP) or one register read (START, addr+W, reg,
// repeated START, addr+R, data, master NACK, STOP) per request.
module sm_twi_engine #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] chip_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] data_in,
  input  logic       wr,
  input  logic       rd,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_i
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, REG, DATA_W, RSTART, ADDR_R, DATA_R, MACK, STOP
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  phase, phase_nx;
  logic [3:0]  bitn, bitn_nx;
  logic [7:0]  qcnt;
  logic        tick;
  logic        accept, finish, set_nack;
  logic [6:0]  chip_q;
  logic [7:0]  reg_q, dat_q, rx_sh, tx_byte;
  logic        op_rd;
  logic        tx_bit;

  assign tick   = busy && (qcnt == 8'(CLK_DIV - 1));
  assign accept = (state == IDLE) && (wr || rd);

  // Quarter-period prescaler, held at zero whenever the engine is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              qcnt <= '0;
    else if (!busy || tick)  qcnt <= '0;
    else                     qcnt <= qcnt + 8'd1;
  end

  // FSM state, quarter phase and bit index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= '0;
      bitn  <= '0;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
      bitn  <= bitn_nx;
    end
  end

  // Next-state logic: phases advance on ticks, bit/byte decisions at end of q3
  always_comb begin
    state_nx = state;
    phase_nx = phase;
    bitn_nx  = bitn;
    finish   = 1'b0;
    set_nack = 1'b0;
    if (state == IDLE) begin
      if (wr || rd) begin
        state_nx = START;
        phase_nx = '0;
        bitn_nx  = '0;
      end
    end else if (tick) begin
      phase_nx = phase + 2'd1;
      if (phase == 2'd3) begin
        case (state)
          START:  begin state_nx = ADDR_W; bitn_nx = '0; end
          ADDR_W, REG, DATA_W, ADDR_R: begin
            if (bitn == 4'd8) begin
              bitn_nx = '0;
              if (sda_i) begin
                state_nx = STOP;
                set_nack = 1'b1;
              end else begin
                case (state)
                  ADDR_W:  state_nx = REG;
                  REG:     state_nx = op_rd ? RSTART : DATA_W;
                  ADDR_R:  state_nx = DATA_R;
                  default: state_nx = STOP;
                endcase
              end
            end else begin
              bitn_nx = bitn + 4'd1;
            end
          end
          RSTART: begin state_nx = ADDR_R; bitn_nx = '0; end
          DATA_R: begin
            if (bitn == 4'd7) begin
              state_nx = MACK;
              bitn_nx  = '0;
            end else begin
              bitn_nx = bitn + 4'd1;
            end
          end
          MACK:   state_nx = STOP;
          STOP: begin
            state_nx = IDLE;
            finish   = 1'b1;
          end
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  // Request shadowing, status flags and receive shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chip_q   <= '0;
      reg_q    <= '0;
      dat_q    <= '0;
      op_rd    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
      rx_sh    <= '0;
      data_out <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        chip_q <= chip_addr;
        reg_q  <= reg_addr;
        dat_q  <= data_in;
        op_rd  <= !wr;
        busy   <= 1'b1;
        nack   <= 1'b0;
      end
      if (set_nack) nack <= 1'b1;
      if (tick && phase == 2'd3 && state == DATA_R) rx_sh <= {rx_sh[6:0], sda_i};
      if (finish) begin
        busy <= 1'b0;
        if (op_rd && !nack) data_out <= rx_sh;
      end
    end
  end

  // Byte currently being shifted out, and its bit for this bit slot
  always_comb begin
    case (state)
      ADDR_W:  tx_byte = {chip_q, 1'b0};
      REG:     tx_byte = reg_q;
      DATA_W:  tx_byte = dat_q;
      ADDR_R:  tx_byte = {chip_q, 1'b1};
      default: tx_byte = '0;
    endcase
    tx_bit = tx_byte[3'd7 - bitn[2:0]];
  end

  // Pin decode from state and quarter phase; idle/reset leaves the bus released
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state)
      START: begin
        scl    = (phase != 2'd3);
        sda_oe = (phase != 2'd0);
      end
      RSTART: begin
        scl    = (phase == 2'd1) || (phase == 2'd2);
        sda_oe = phase[1];
      end
      STOP: begin
        scl    = (phase != 2'd0);
        sda_oe = (phase != 2'd3);
      end
      ADDR_W, REG, DATA_W, ADDR_R: begin
        scl    = phase[1];
        sda_oe = (bitn != 4'd8) && !tx_bit;
      end
      DATA_R, MACK: begin
        scl    = phase[1];
        sda_oe = 1'b0;
      end
      default: begin
        scl    = 1'b1;
        sda_oe = 1'b0;
      end
    endcase
  end

endmodule
